// File: rtl/issue_if.sv
// Decoder-to-scheduler-to-unit signal bundle for the issue stage.
// master = the decoder/unit/writeback side, slave = the scheduler.
interface issue_if #(
    parameter int STALL_CNT_W = 16
);
    // decoded instruction
    logic                   in_valid;
    logic                   in_ready;
    logic [4:0]             in_rd_addr;
    logic [4:0]             in_rs1_addr;
    logic [4:0]             in_rs2_addr;
    logic                   in_operand_a_enable;
    logic                   in_operand_b_enable;
    logic                   in_result_enable;
    logic                   in_rd_is_operand_a;
    logic                   in_use_alu;
    logic                   in_use_fpu;
    logic                   in_is_load;
    logic                   in_is_store;
    logic                   in_is_jump;
    logic                   in_is_jump_register;
    logic [2:0]             in_condition;
    // unit issue side
    logic                   alu_issue;
    logic                   fpu_issue;
    logic                   mem_issue;
    logic                   fpu_ready;
    logic                   mem_ready;
    // writeback and fetch feedback
    logic                   int_wb_valid;
    logic [4:0]             int_wb_addr;
    logic                   fpu_wb_valid;
    logic [4:0]             fpu_wb_addr;
    logic                   redirect_valid;
    // status
    logic [2:0]             fpu_inflight;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output in_valid, in_rd_addr, in_rs1_addr, in_rs2_addr,
               in_operand_a_enable, in_operand_b_enable, in_result_enable,
               in_rd_is_operand_a, in_use_alu, in_use_fpu, in_is_load,
               in_is_store, in_is_jump, in_is_jump_register, in_condition,
               fpu_ready, mem_ready, int_wb_valid, int_wb_addr,
               fpu_wb_valid, fpu_wb_addr, redirect_valid,
        input  in_ready, alu_issue, fpu_issue, mem_issue,
               fpu_inflight, stall_cycles
    );

    modport slave (
        input  in_valid, in_rd_addr, in_rs1_addr, in_rs2_addr,
               in_operand_a_enable, in_operand_b_enable, in_result_enable,
               in_rd_is_operand_a, in_use_alu, in_use_fpu, in_is_load,
               in_is_store, in_is_jump, in_is_jump_register, in_condition,
               fpu_ready, mem_ready, int_wb_valid, int_wb_addr,
               fpu_wb_valid, fpu_wb_addr, redirect_valid,
        output in_ready, alu_issue, fpu_issue, mem_issue,
               fpu_inflight, stall_cycles
    );
endinterface

// File: rtl/issue_scheduler.sv
// In-order single-issue scheduler: scoreboard hazard check, unit
// back-pressure, FPU window limit and control-flow redirect wait.
module issue_scheduler #(
    parameter int FPU_DEPTH   = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    issue_if.slave bus
);
    typedef enum logic [0:0] {
        RUN           = 1'b0,
        REDIRECT_WAIT = 1'b1
    } state_t;

    state_t                 state;
    logic [31:0]            scoreboard;
    logic [2:0]             fpu_inflight_q;
    logic [STALL_CNT_W-1:0] stall_q;

    logic [4:0]  src_a;
    logic        cls_mem, cls_fpu, cls_alu;
    logic        ctrl_flow, has_dst, hazard, fpu_room, ready, accept;
    logic        fpu_dec;
    logic [31:0] sb_set, sb_clr, sb_next;

    // in_use_alu is implied by the class priority; alu is the fallback class
    logic unused_in_use_alu;
    assign unused_in_use_alu = bus.in_use_alu;

    // register 0 is hard-wired and never pending
    function automatic logic is_busy(input logic [31:0] sb, input logic [4:0] a);
        return (a != 5'd0) && sb[a];
    endfunction

    // decode class, operands and destination; evaluate hazards and readiness
    always_comb begin
        src_a     = bus.in_rd_is_operand_a ? bus.in_rd_addr : bus.in_rs1_addr;
        cls_mem   = bus.in_is_load || bus.in_is_store;
        cls_fpu   = !cls_mem && bus.in_use_fpu;
        cls_alu   = !cls_mem && !cls_fpu && !bus.in_is_jump;
        ctrl_flow = bus.in_is_jump || bus.in_is_jump_register ||
                    (bus.in_condition != 3'b111);
        has_dst   = (bus.in_result_enable || bus.in_is_load) &&
                    !bus.in_is_store && !ctrl_flow;

        hazard = 1'b0;
        if (bus.in_operand_a_enable && is_busy(scoreboard, src_a))           hazard = 1'b1;
        if (bus.in_operand_b_enable && is_busy(scoreboard, bus.in_rs2_addr)) hazard = 1'b1;
        if (bus.in_is_store && is_busy(scoreboard, bus.in_rs1_addr))         hazard = 1'b1;
        if (has_dst && is_busy(scoreboard, bus.in_rd_addr))                  hazard = 1'b1;

        fpu_room = fpu_inflight_q < 3'(FPU_DEPTH);
        ready    = rst_n && (state == RUN) && !hazard &&
                   (!cls_mem || bus.mem_ready) &&
                   (!cls_fpu || (bus.fpu_ready && fpu_room));
        accept   = bus.in_valid && ready;
    end

    assign bus.in_ready     = ready;
    assign bus.alu_issue    = accept && cls_alu;
    assign bus.fpu_issue    = accept && cls_fpu;
    assign bus.mem_issue    = accept && cls_mem;
    assign bus.fpu_inflight = fpu_inflight_q;
    assign bus.stall_cycles = stall_q;

    // scoreboard next value: retire both writeback ports, then mark new dest
    always_comb begin
        sb_clr = '0;
        sb_set = '0;
        if (bus.int_wb_valid) sb_clr[bus.int_wb_addr] = 1'b1;
        if (bus.fpu_wb_valid) sb_clr[bus.fpu_wb_addr] = 1'b1;
        if (accept && has_dst) sb_set[bus.in_rd_addr] = 1'b1;
        sb_next = ((scoreboard & ~sb_clr) | sb_set) & ~32'd1;
    end

    // pending-write scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scoreboard <= '0;
        else        scoreboard <= sb_next;
    end

    // a writeback with nothing outstanding must not underflow the window
    assign fpu_dec = bus.fpu_wb_valid && (fpu_inflight_q != 3'd0);

    // FPU operations in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fpu_inflight_q <= '0;
        else        fpu_inflight_q <= fpu_inflight_q + 3'(bus.fpu_issue) - 3'(fpu_dec);
    end

    // hold issue after control flow until fetch has redirected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:           if (accept && ctrl_flow) state <= REDIRECT_WAIT;
                REDIRECT_WAIT: if (bus.redirect_valid)  state <= RUN;
                default:       state <= RUN;
            endcase
        end
    end

    // saturating count of cycles the decoder was held off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (bus.in_valid && !ready && (stall_q != {STALL_CNT_W{1'b1}}))
            stall_q <= stall_q + 1'b1;
    end
endmodule
